// File: rtl/pipe_collect_pkg.sv
// Shared defaults and helpers for the pipeline credit collector.
package pipe_collect_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LATENCY    = 2;
    localparam int unsigned DEF_DEPTH      = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_collect_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module pipe_collect_fifo
    import pipe_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = credit_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy, wrapping explicitly for non-power-of-two depths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_credit_collector.sv
// Credit-based wrapper that issues requests into a fixed-latency valid-only pipeline
// and collects its results in order into a FIFO sized to the credit pool.
module pipe_credit_collector
    import pipe_collect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [DATA_WIDTH-1:0]             req_data,
    output logic                              pipe_input_valid,
    output logic [DATA_WIDTH-1:0]             pipe_x,
    input  logic                              pipe_output_valid,
    input  logic [DATA_WIDTH-1:0]             pipe_out,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [credit_width(DEPTH)-1:0]    credits,
    output logic                              stray_err
);

    localparam int unsigned CW = credit_width(DEPTH);

    // Latency only documents the attached pipeline; zero latency would break result ordering.
    if (LATENCY == 0 || DEPTH < 2 || DEPTH > 16) begin : g_unsupported_config
    end

    logic issue;
    logic pop;
    logic push;
    logic stray;
    logic fifo_full;
    logic fifo_empty;

    assign req_ready        = (credits != '0);
    assign issue            = req_valid && req_ready;
    assign pipe_input_valid = issue;
    assign pipe_x           = req_data;
    assign resp_valid       = !fifo_empty;
    assign pop              = resp_valid && resp_ready;

    // A result is stray when nothing is in flight, or there is nowhere to put it.
    assign stray = pipe_output_valid && ((credits == CW'(DEPTH)) || (fifo_full && !pop));
    assign push  = pipe_output_valid && !stray;

    pipe_collect_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pipe_out),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (resp_data)
    );

    // Credit pool: issue takes one, pop returns one; saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(DEPTH);
        end else if (issue && !pop) begin
            credits <= credits - CW'(1);
        end else if (pop && !issue && (credits != CW'(DEPTH))) begin
            credits <= credits + CW'(1);
        end
    end

    // Sticky stray-result flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stray_err <= 1'b0;
        end else if (stray) begin
            stray_err <= 1'b1;
        end
    end

endmodule

// File: doc/pipe_credit_collector.md
PIPE_CREDIT_COLLECTOR -- requirements
Module: pipe_credit_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the payload width of all data ports.
REQ-002 Parameter LATENCY, default 2, is the fixed cycle latency of the attached valid-only pipeline; it is documentation only and no logic depends on it.
REQ-003 Parameter DEPTH, default 4, sets the result FIFO depth and the total credit pool; the legal range is 2..16.
REQ-004 The block has one clock and reset is asynchronous, active-high; the ports are clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  upstream request valid.
REQ-008 req_ready  out  1  upstream request ready.
REQ-009 req_data  in  DATA_WIDTH  upstream request payload.
REQ-010 pipe_input_valid  out  1  issue strobe to the pipeline's input_valid.
REQ-011 pipe_x  out  DATA_WIDTH  operand to the pipeline's x input.
REQ-012 pipe_output_valid  in  1  result strobe from the pipeline's output_valid.
REQ-013 pipe_out  in  DATA_WIDTH  result from the pipeline's out.
REQ-014 resp_valid  out  1  downstream response valid.
REQ-015 resp_ready  in  1  downstream response ready.
REQ-016 resp_data  out  DATA_WIDTH  downstream response payload.
REQ-017 credits  out  $clog2(DEPTH+1)  free credits (DEPTH minus in-flight minus FIFO occupancy).
REQ-018 stray_err  out  1  sticky flag: a result arrived that no credit accounts for.

Function
REQ-019 req_ready SHALL equal (credits != 0), with no combinational path from req_valid.
REQ-020 An issue occurs when req_valid && req_ready; in that same cycle, combinationally, pipe_input_valid SHALL be 1 and pipe_x SHALL equal req_data.
REQ-021 When no issue occurs, pipe_input_valid SHALL be 0; pipe_x always reflects req_data.
REQ-022 A pop occurs when resp_valid && resp_ready.
REQ-023 Credit update per cycle: issue only gives -1; pop only gives +1; issue and pop together leave credits unchanged; neither leaves it unchanged.
REQ-024 credits SHALL never exceed DEPTH nor go below 0.
REQ-025 On pipe_output_valid, pipe_out SHALL be pushed to the FIFO tail.
REQ-026 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 resp_valid SHALL equal FIFO not-empty, and resp_data SHALL equal the FIFO head; there is no bypass, so a pushed value becomes visible the cycle after the push.
REQ-028 End-to-end latency: a request accepted in cycle t SHALL appear on resp_valid at t+LATENCY+1 when the FIFO is empty.
REQ-029 Ordering SHALL be strictly FIFO: responses leave in request order.
REQ-030 If pipe_output_valid arrives while credits==DEPTH, or while the FIFO is full with no pop, the data SHALL be dropped, stray_err SHALL set, and credits SHALL be unchanged.
REQ-031 stray_err SHALL clear only on reset.
REQ-032 resp_valid held with resp_ready low SHALL keep resp_data stable.
REQ-033 With DEPTH back-to-back issues and resp_ready low, req_ready SHALL drop the cycle after the DEPTH-th issue and the FIFO SHALL fill without loss.

Reset
REQ-034 On rst assertion, asynchronously: credits=DEPTH, FIFO empty, resp_valid=0, stray_err=0, req_ready=1.
REQ-035 Reset mid-operation SHALL discard all FIFO contents and in-flight accounting; the attached pipeline SHALL share rst so that no stale results arrive afterwards.
REQ-036 resp_data is don't-care while resp_valid=0.

Structure
REQ-037 Package pipe_collect_pkg SHALL hold the default DATA_WIDTH/LATENCY/DEPTH constants and the credit-width helper function.
REQ-038 Sub-module pipe_collect_fifo (synchronous FIFO with push, pop, full, empty, and head outputs) SHALL implement the buffer; the credit counter and error flag stay in the top module.

Verification
REQ-039 Reset, then a single request 0x0000_0005 with an add-one pipeline and resp_ready=1 -> resp_data=0x0000_0006 with resp_valid at t+3; credits returns to 4.
REQ-040 Issue 4 requests 1,2,3,4 back-to-back with resp_ready=0 -> req_ready=0 after the 4th and credits=0; raise resp_ready -> responses 2,3,4,5 in order, then credits=4.
REQ-041 Sustained req_valid=1 and resp_ready=1 for 20 cycles -> one issue per cycle, credits never below DEPTH-LATENCY-1, and no stray_err.
REQ-042 Inject pipe_output_valid=1 with credits=4 -> stray_err=1, FIFO stays empty, and the flag holds until rst.
REQ-043 Assert rst with FIFO occupancy 3 -> resp_valid=0 and credits=4 immediately (asynchronously); after release, the next request completes normally.
REQ-044 FIFO full with a simultaneous push and pop -> both accepted, occupancy unchanged, and head advances by one.
